md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_if.sv | 15 +
 rtl/md_unit.sv | 128 ++++++++++++
 tb/tb_md_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle for the iterative multiply/divide unit.
interface md_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - radix-2 multiply/divide unit with HI/LO result registers.
// Operates on magnitudes for WIDTH cycles and fixes up signs on the way into DONE.
module md_unit #(parameter int WIDTH = 32) (
  input  logic      clk,
  input  logic      rst,
  md_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q;
  logic [2:0]         op_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic               is_sgn, is_div, neg_a, neg_b, in_sgn, in_div, ge;
  logic [WIDTH-1:0]   mag_a, mag_b, rem_new, quo, rem, res_hi, res_lo, p_init;
  logic [WIDTH:0]     add_sum, shifted;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    is_sgn  = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    neg_a   = is_sgn && a_q[WIDTH-1];
    neg_b   = is_sgn && b_q[WIDTH-1];
    mag_a   = mag(a_q, is_sgn);
    mag_b   = mag(b_q, is_sgn);
    in_sgn  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    in_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    // Divide iterates on the dividend; multiply shifts the multiplier out of the low half.
    p_init  = mag(in_div ? bus.a : bus.b, in_sgn);

    add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mag_a} : '0);
    shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge      = shifted[WIDTH] || (shifted[WIDTH-1:0] >= mag_b);
    rem_new = ge ? (shifted[WIDTH-1:0] - mag_b) : shifted[WIDTH-1:0];
    p_d     = is_div ? {rem_new, p_q[WIDTH-2:0], ge} : {add_sum, p_q[WIDTH-1:1]};

    quo     = p_d[WIDTH-1:0];
    rem     = p_d[2*WIDTH-1:WIDTH];
    prod_s  = (neg_a ^ neg_b) ? -p_d : p_d;
    res_hi  = prod_s[2*WIDTH-1:WIDTH];
    res_lo  = prod_s[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_a ? -rem : rem;
        res_lo = (neg_a ^ neg_b) ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (bus.op == OP_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.a;
            end else if (bus.op >= OP_MULT && bus.op <= OP_DIVU) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              a_q     <= bus.a;
              b_q     <= bus.b;
              op_q    <= bus.op;
              cnt_q   <= '0;
              p_q     <= {{WIDTH{1'b0}}, p_init};
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            p_q   <= p_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              cnt_q   <= '0;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit against an arithmetic reference model.
module tb_md_unit;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100;
  localparam logic [2:0] MTHI = 3'b101, MTLO = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi, m_lo;

  md_unit_if #(.WIDTH(W)) bus();
  md_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (op)
      MULT:  r = 64'(sa * sb);
      MULTU: r = 64'(a) * 64'(b);
      DIV:   r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = s;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
  endtask

  // Issues one mult/div and checks the busy window and the done cycle; values go through the scoreboard.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input bit hold);
    bit busy_ok;
    @(posedge clk); #1;
    drive(1'b1, op, x, y);
    exp_q.push_back({eh, el});
    @(posedge clk); #1;
    if (hold) drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    else      drive(1'b0, 3'b000, '0, '0);
    busy_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (!(bus.busy === 1'b1 && bus.done === 1'b0)) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (hold) drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    check("busy_window", busy_ok, 1);
    @(negedge clk);
    check("done_cycle", {bus.done, bus.busy}, 2'b10);
    drive(1'b0, 3'b000, '0, '0);
    m_hi = eh;
    m_lo = el;
  endtask

  // A start that must leave the unit idle and HI/LO untouched (or written, for MTHI/MTLO).
  task automatic short_op(input string name, input logic [2:0] op, input logic [31:0] x, input logic f);
    @(posedge clk); #1;
    drive(1'b1, op, x, 32'h5);
    bus.flush = f;
    @(posedge clk); #1;
    drive(1'b0, 3'b000, '0, '0);
    bus.flush = 1'b0;
    if (!f && op == MTHI) m_hi = x;
    if (!f && op == MTLO) m_lo = x;
    @(negedge clk);
    check(name, {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, m_hi, m_lo});
  endtask

  task automatic abort_op(input bit use_rst);
    bit quiet;
    @(posedge clk); #1;
    drive(1'b1, DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 3'b000, '0, '0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_busy10", bus.busy, 1'b1);
    if (use_rst) rst = 1'b1;
    else         bus.flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.flush = 1'b0;
    if (use_rst) begin
      m_hi = '0;
      m_lo = '0;
    end
    quiet = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
    end
    check(use_rst ? "rst_abort_quiet" : "flush_abort_quiet", quiet, 1);
    check(use_rst ? "rst_abort_hilo" : "flush_abort_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hi", bus.hi, mon_e[63:32]);
        check("result_lo", bus.lo, mon_e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    drive(1'b1, DIV, 32'h7, 32'h2);
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 3'b000, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, 64'h0});

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op(DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    run_op(DIVU,  32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b0);
    run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1);

    short_op("mthi_write", MTHI, 32'h1234, 1'b0);
    abort_op(1'b0);
    abort_op(1'b1);

    short_op("mtlo_write", MTLO, 32'hCAFE0001, 1'b0);
    short_op("noop_000", 3'b000, 32'hDEAD, 1'b0);
    short_op("noop_111", 3'b111, 32'hBEEF, 1'b0);
    short_op("flush_drops_mthi", MTHI, 32'h5555, 1'b1);
    short_op("flush_drops_mult", MULT, 32'h7777, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      logic [63:0] r;
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        1: y = '0;
        2: begin
          x = 32'($urandom_range(0, 300));
          y = 32'($urandom_range(1, 17));
          if ($urandom_range(0, 1) == 1) y = -y;
          if ($urandom_range(0, 1) == 1) x = -x;
        end
        3: begin
          x = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
          y = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000;
        end
        default: ;
      endcase
      r = model(o, x, y);
      run_op(o, x, y, r[63:32], r[31:0], $urandom_range(0, 1) == 1);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
